vc_route_stage: RTL and testbench

// - Downstream consumer of one vc_buffer in a RaveNOC router input port: pops flits via valid/ready,

---
 rtl/noc_pkg.sv | 38 +++
 rtl/noc_xy_route.sv | 28 ++
 rtl/vc_route_stage.sv | 137 +++++++++++++
 tb/tb_vc_route_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit field layout, flit types, route one-hot bits and route-stage states.
package noc_pkg;

    localparam int unsigned FLIT_W   = 34;
    localparam int unsigned COORD_W  = 4;
    localparam int unsigned VC_W     = 2;
    localparam int unsigned ROUTE_W  = 5;

    // Flit field positions
    localparam int unsigned TYPE_LSB = 32;
    localparam int unsigned TYPE_W   = 2;
    localparam int unsigned DX_LSB   = 26;
    localparam int unsigned DY_LSB   = 22;

    // One-hot output-port request bit indices
    localparam int unsigned RT_LOCAL = 0;
    localparam int unsigned RT_NORTH = 1;
    localparam int unsigned RT_SOUTH = 2;
    localparam int unsigned RT_EAST  = 3;
    localparam int unsigned RT_WEST  = 4;

    typedef enum logic [TYPE_W-1:0] {
        FLIT_HEAD = 2'b00,
        FLIT_BODY = 2'b01,
        FLIT_RSVD = 2'b10,
        FLIT_TAIL = 2'b11
    } flit_type_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } route_state_e;

    function automatic flit_type_e flit_type(input logic [FLIT_W-1:0] flit);
        return flit_type_e'(flit[TYPE_LSB +: TYPE_W]);
    endfunction

endpackage

// File: rtl/noc_xy_route.sv
// Dimension-ordered XY routing: resolve X first, then Y, else deliver locally.
module noc_xy_route
    import noc_pkg::*;
#(
    parameter logic [COORD_W-1:0] ROUTER_X = '0,
    parameter logic [COORD_W-1:0] ROUTER_Y = '0
) (
    input  logic [COORD_W-1:0] dest_x_i,
    input  logic [COORD_W-1:0] dest_y_i,
    output logic [ROUTE_W-1:0] route_c_o
);

    always_comb begin
        route_c_o = '0;
        if (dest_x_i > ROUTER_X) begin
            route_c_o[RT_EAST] = 1'b1;
        end else if (dest_x_i < ROUTER_X) begin
            route_c_o[RT_WEST] = 1'b1;
        end else if (dest_y_i > ROUTER_Y) begin
            route_c_o[RT_NORTH] = 1'b1;
        end else if (dest_y_i < ROUTER_Y) begin
            route_c_o[RT_SOUTH] = 1'b1;
        end else begin
            route_c_o[RT_LOCAL] = 1'b1;
        end
    end

endmodule

// File: rtl/vc_route_stage.sv
// Router input-port route stage: pops flits from a VC buffer, XY-routes each head,
// holds the route for the packet and presents flit + request through one register stage.
module vc_route_stage
    import noc_pkg::*;
#(
    parameter logic [COORD_W-1:0] ROUTER_X = '0,
    parameter logic [COORD_W-1:0] ROUTER_Y = '0,
    parameter int unsigned        FLIT_W   = noc_pkg::FLIT_W
) (
    input  logic                clk,
    input  logic                arst,
    input  logic [FLIT_W-1:0]   fdata_i,
    input  logic [VC_W-1:0]     vc_id_i,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [FLIT_W-1:0]   fdata_o,
    output logic [VC_W-1:0]     vc_id_o,
    output logic [ROUTE_W-1:0]  route_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic                locked_o,
    output logic                err_o
);

    route_state_e        state_q, state_d;
    logic                valid_q, valid_d;
    logic [FLIT_W-1:0]   fdata_q, fdata_d;
    logic [ROUTE_W-1:0]  route_q, route_d;
    logic [VC_W-1:0]     vc_q, vc_d;
    logic [ROUTE_W-1:0]  pkt_route_q, pkt_route_d;
    logic [VC_W-1:0]     pkt_vc_q, pkt_vc_d;
    logic                err_q, err_d;

    logic [ROUTE_W-1:0]  head_route;
    logic                in_fire;
    logic                out_fire;
    flit_type_e          in_type;

    noc_xy_route #(
        .ROUTER_X (ROUTER_X),
        .ROUTER_Y (ROUTER_Y)
    ) u_xy_route (
        .dest_x_i  (fdata_i[DX_LSB +: COORD_W]),
        .dest_y_i  (fdata_i[DY_LSB +: COORD_W]),
        .route_c_o (head_route)
    );

    // Skid-free pipeline: accept whenever the output slot is empty or draining this cycle
    assign ready_o  = ~valid_q | ready_i;
    assign in_fire  = valid_i & ready_o;
    assign out_fire = valid_q & ready_i;
    assign in_type  = flit_type_e'(fdata_i[TYPE_LSB +: TYPE_W]);

    always_ff @(posedge clk) begin
        if (!arst) begin
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            fdata_q     <= '0;
            route_q     <= '0;
            vc_q        <= '0;
            pkt_route_q <= '0;
            pkt_vc_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            fdata_q     <= fdata_d;
            route_q     <= route_d;
            vc_q        <= vc_d;
            pkt_route_q <= pkt_route_d;
            pkt_vc_q    <= pkt_vc_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        fdata_d     = fdata_q;
        route_d     = route_q;
        vc_d        = vc_q;
        pkt_route_d = pkt_route_q;
        pkt_vc_d    = pkt_vc_q;
        err_d       = 1'b0;

        // Drained slot drops its request so route_o is zero whenever valid_o is low
        if (out_fire) begin
            valid_d = 1'b0;
            route_d = '0;
        end

        if (in_fire) begin
            case (in_type)
                FLIT_HEAD: begin
                    // A head inside a packet is flagged but still starts a fresh packet
                    err_d       = (state_q == ST_PKT);
                    state_d     = ST_PKT;
                    pkt_route_d = head_route;
                    pkt_vc_d    = vc_id_i;
                    valid_d     = 1'b1;
                    fdata_d     = fdata_i;
                    route_d     = head_route;
                    vc_d        = vc_id_i;
                end
                FLIT_TAIL: begin
                    if (state_q == ST_PKT) begin
                        state_d = ST_IDLE;
                        valid_d = 1'b1;
                        fdata_d = fdata_i;
                        route_d = pkt_route_q;
                        vc_d    = pkt_vc_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                default: begin
                    if (state_q == ST_PKT) begin
                        valid_d = 1'b1;
                        fdata_d = fdata_i;
                        route_d = pkt_route_q;
                        vc_d    = pkt_vc_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    assign valid_o  = valid_q;
    assign fdata_o  = fdata_q;
    assign route_o  = route_q;
    assign vc_id_o  = vc_q;
    assign locked_o = (state_q == ST_PKT);
    assign err_o    = err_q;

endmodule

// File: tb/tb_vc_route_stage.sv
// Bench for vc_route_stage at router (1,1): directed scenarios plus random traffic
// against a queue-based packet model.
module tb_vc_route_stage;

    localparam logic [3:0] RX = 4'd1;
    localparam logic [3:0] RY = 4'd1;

    logic        clk = 1'b0;
    logic        arst;
    logic [33:0] fdata_i;
    logic [1:0]  vc_id_i;
    logic        valid_i;
    logic        ready_o;
    logic [33:0] fdata_o;
    logic [1:0]  vc_id_o;
    logic [4:0]  route_o;
    logic        valid_o;
    logic        ready_i;
    logic        locked_o;
    logic        err_o;

    always #5 clk = ~clk;

    vc_route_stage #(
        .ROUTER_X (RX),
        .ROUTER_Y (RY),
        .FLIT_W   (34)
    ) dut (
        .clk      (clk),
        .arst     (arst),
        .fdata_i  (fdata_i),
        .vc_id_i  (vc_id_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .fdata_o  (fdata_o),
        .vc_id_o  (vc_id_o),
        .route_o  (route_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .locked_o (locked_o),
        .err_o    (err_o)
    );

    typedef struct {
        logic [33:0] f;
        logic [4:0]  r;
        logic [1:0]  vc;
    } ent_t;

    ent_t        exp_q[$];
    bit          in_pkt;
    logic [4:0]  pkt_r;
    logic [1:0]  pkt_vc;
    bit          exp_err;
    bit          chk_en;
    int          vectors = 0;
    int          ncmp = 0;
    int          miscompares = 0;

    function automatic logic [33:0] mk(input int t, input int dx, input int dy, input int pay);
        logic [33:0] f;
        f = '0;
        f[33:32] = 2'(t);
        f[29:26] = 4'(dx);
        f[25:22] = 4'(dy);
        f[21:0]  = 22'(pay);
        return f;
    endfunction

    // Reference XY decision from the coordinate rules
    function automatic logic [4:0] xy(input int dx, input int dy);
        if (dx > int'(RX)) return 5'b01000;
        if (dx < int'(RX)) return 5'b10000;
        if (dy > int'(RY)) return 5'b00010;
        if (dy < int'(RY)) return 5'b00100;
        return 5'b00001;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // One clock: drive, compare against the model before the edge, advance the model at the edge
    task automatic step(input logic a, input logic v, input logic [33:0] f,
                        input logic [1:0] vc, input logic r);
        bit   rdy, inf, outf, nerr;
        ent_t e;
        arst = a; valid_i = v; fdata_i = f; vc_id_i = vc; ready_i = r;
        vectors++;
        @(negedge clk);
        if (chk_en) begin
            check("valid_o", 64'(valid_o), 64'(exp_q.size() > 0));
            check("ready_o", 64'(ready_o), 64'(exp_q.size() == 0 || r));
            check("locked_o", 64'(locked_o), 64'(in_pkt));
            check("err_o", 64'(err_o), 64'(exp_err));
            if (exp_q.size() > 0) begin
                check("fdata_o", 64'(fdata_o), 64'(exp_q[0].f));
                check("route_o", 64'(route_o), 64'(exp_q[0].r));
                check("vc_id_o", 64'(vc_id_o), 64'(exp_q[0].vc));
                check("route_onehot", 64'($countones(route_o)), 64'(1));
            end else begin
                check("route_idle", 64'(route_o), 64'(0));
            end
        end
        rdy  = (exp_q.size() == 0) || r;
        inf  = v && rdy;
        outf = (exp_q.size() > 0) && r;
        @(posedge clk);
        nerr = 1'b0;
        if (!a) begin
            exp_q.delete();
            in_pkt = 1'b0;
        end else begin
            if (outf) void'(exp_q.pop_front());
            if (inf) begin
                e.f = f;
                if (f[33:32] == 2'b00) begin
                    nerr   = in_pkt;
                    in_pkt = 1'b1;
                    pkt_r  = xy(int'(f[29:26]), int'(f[25:22]));
                    pkt_vc = vc;
                    e.r = pkt_r; e.vc = pkt_vc;
                    exp_q.push_back(e);
                end else if (!in_pkt) begin
                    nerr = 1'b1;
                end else begin
                    e.r = pkt_r; e.vc = pkt_vc;
                    exp_q.push_back(e);
                    if (f[33:32] == 2'b11) in_pkt = 1'b0;
                end
            end
        end
        exp_err = nerr;
        chk_en  = 1'b1;
        #1;
    endtask

    initial begin
        int t;
        int r;
        arst = 1'b0; valid_i = 1'b0; fdata_i = '0; vc_id_i = '0; ready_i = 1'b0;
        in_pkt = 1'b0; pkt_r = '0; pkt_vc = '0; exp_err = 1'b0; chk_en = 1'b0;

        // Reset held two cycles with valid_i asserted
        step(1'b0, 1'b1, mk(0, 3, 1, 5), 2'd1, 1'b1);
        step(1'b0, 1'b1, mk(0, 3, 1, 5), 2'd1, 1'b1);
        check("rst_valid", 64'(valid_o), 64'(0));
        check("rst_route", 64'(route_o), 64'(0));
        check("rst_locked", 64'(locked_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_fdata", 64'(fdata_o), 64'(0));

        // Head (3,1), body, tail back to back: east for all three
        step(1'b1, 1'b1, mk(0, 3, 1, 11), 2'd2, 1'b1);
        check("east_head_route", 64'(route_o), 64'(5'b01000));
        check("east_head_locked", 64'(locked_o), 64'(1));
        step(1'b1, 1'b1, mk(1, 0, 0, 12), 2'd0, 1'b1);
        check("east_body_route", 64'(route_o), 64'(5'b01000));
        check("east_body_vc", 64'(vc_id_o), 64'(2));
        step(1'b1, 1'b1, mk(3, 0, 0, 13), 2'd3, 1'b1);
        check("east_tail_route", 64'(route_o), 64'(5'b01000));
        check("east_tail_locked", 64'(locked_o), 64'(0));
        step(1'b1, 1'b0, '0, 2'd0, 1'b1);
        check("east_drained", 64'(valid_o), 64'(0));

        // Single-flit style packets to the other directions
        step(1'b1, 1'b1, mk(0, 1, 1, 21), 2'd1, 1'b1);
        check("local_route", 64'(route_o), 64'(5'b00001));
        step(1'b1, 1'b1, mk(3, 0, 0, 22), 2'd1, 1'b1);
        step(1'b1, 1'b1, mk(0, 1, 0, 23), 2'd1, 1'b1);
        check("south_route", 64'(route_o), 64'(5'b00100));
        step(1'b1, 1'b1, mk(3, 0, 0, 24), 2'd1, 1'b1);
        step(1'b1, 1'b1, mk(0, 0, 2, 25), 2'd1, 1'b1);
        check("west_route", 64'(route_o), 64'(5'b10000));
        step(1'b1, 1'b1, mk(3, 0, 0, 26), 2'd1, 1'b1);
        step(1'b1, 1'b0, '0, 2'd0, 1'b1);

        // Backpressure: output held for three stalled cycles
        step(1'b1, 1'b1, mk(0, 1, 3, 31), 2'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, mk(1, 0, 0, 32), 2'd0, 1'b0);
            check("bp_ready", 64'(ready_o), 64'(0));
            check("bp_fdata", 64'(fdata_o), 64'(mk(0, 1, 3, 31)));
            check("bp_route", 64'(route_o), 64'(5'b00010));
        end
        step(1'b1, 1'b1, mk(1, 0, 0, 32), 2'd0, 1'b1);
        check("bp_next_fdata", 64'(fdata_o), 64'(mk(1, 0, 0, 32)));
        step(1'b1, 1'b1, mk(3, 0, 0, 33), 2'd0, 1'b1);
        step(1'b1, 1'b0, '0, 2'd0, 1'b1);

        // Body in IDLE: consumed, dropped, one-cycle error
        step(1'b1, 1'b1, mk(1, 0, 0, 41), 2'd0, 1'b1);
        check("idle_body_valid", 64'(valid_o), 64'(0));
        check("idle_body_err", 64'(err_o), 64'(1));
        step(1'b1, 1'b0, '0, 2'd0, 1'b1);
        check("idle_body_err_clear", 64'(err_o), 64'(0));

        // Reset between head and tail
        step(1'b1, 1'b1, mk(0, 2, 2, 51), 2'd1, 1'b1);
        step(1'b0, 1'b0, '0, 2'd0, 1'b1);
        check("midrst_locked", 64'(locked_o), 64'(0));
        check("midrst_valid", 64'(valid_o), 64'(0));
        step(1'b1, 1'b1, mk(1, 0, 0, 52), 2'd1, 1'b1);
        check("midrst_body_err", 64'(err_o), 64'(1));

        // Random traffic, including stray heads, reserved types and rare resets
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 30) t = 0;
            else if (r < 70) t = 1;
            else if (r < 90) t = 3;
            else t = 2;
            step(($urandom_range(0, 99) != 0),
                 ($urandom_range(0, 99) < 70),
                 mk(t, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom)),
                 2'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < 60));
        end
        for (int n = 0; n < 4; n++) step(1'b1, 1'b0, '0, 2'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
